// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer: op encodings, FSM states and
// op classification helpers.
package mem_seq_pkg;

  localparam logic [2:0] OP_SB   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_SH   = 3'b010;
  localparam logic [2:0] OP_LB   = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_LH   = 3'b101;
  localparam logic [2:0] OP_NONE = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapture,
    StWrite,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ClsLoad,
    ClsStore,
    ClsRmw,
    ClsIllegal
  } op_class_e;

  function automatic op_class_e op_class(input logic [2:0] op);
    op_class_e cls;
    case (op)
      OP_LB, OP_LW, OP_LH: cls = ClsLoad;
      OP_SW:               cls = ClsStore;
      OP_SB, OP_SH:        cls = ClsRmw;
      default:             cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lsb);
    logic bad;
    case (op)
      OP_SH, OP_LH: bad = lsb[0];
      OP_SW, OP_LW: bad = (lsb != 2'b00);
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request/memory bus of the memory access sequencer; master is the control-unit side,
// slave is the sequencer.
interface mem_access_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [2:0]        size_sel;
  logic              mdr_load;
  logic              done;
  logic              err_align;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, mem_addr, mem_wr, size_sel, mdr_load, done, err_align
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, mem_addr, mem_wr, size_sel, mdr_load, done, err_align
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Memory read-latency counter: loads MEM_LAT-1, decrements on request, flags zero.
module mem_wait_counter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CntW = $clog2(MEM_LAT) + 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(MEM_LAT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Multicycle sequencer issuing one memory access per control-unit request; sb/sh use
// read-modify-write. Define MEM_SEQ_ALIGN_CHECK_EN to reject misaligned accesses.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_access_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              mis;
  op_class_e         req_cls, cur_cls;

  assign req_cls = op_class(bus.req_op);
  assign cur_cls = op_class(op_q);

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign mis = misaligned(bus.req_op, bus.req_addr[1:0]);

  always_comb begin
    err_d = err_q;
    if ((state_q == StIdle) && bus.req_valid) begin
      err_d = mis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_align = (state_q == StDone) && err_q;
`else
  assign mis           = 1'b0;
  assign bus.err_align = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          addr_d   = bus.req_addr;
          cnt_load = 1'b1;
          if (mis || (req_cls == ClsIllegal)) begin
            state_d = StDone;
          end else if (req_cls == ClsStore) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_zero) begin
          state_d = (cur_cls == ClsLoad) ? StCapture : StWrite;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StCapture: state_d = StDone;
      // Address is held, so the read data stays valid for the merge during the write.
      StWrite:   state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OP_NONE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
    end
  end

  mem_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign bus.mem_wr    = (state_q == StWrite);
  assign bus.mdr_load  = (state_q == StCapture);
  assign bus.done      = (state_q == StDone);
  assign bus.mem_addr  = addr_q;
  assign bus.size_sel  = op_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench for mem_access_sequencer: two instances (MEM_LAT 1 and 3) checked
// against a per-op timing model.
module tb_mem_access_sequencer;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.ADDR_W(32)) bus0 ();
  mem_access_sequencer_if #(.ADDR_W(32)) bus1 ();

  mem_access_sequencer #(.ADDR_W(32), .MEM_LAT(LAT0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  mem_access_sequencer #(.ADDR_W(32), .MEM_LAT(LAT1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic [1:0]  req_valid;
  logic [2:0]  req_op   [2];
  logic [31:0] req_addr [2];
  logic [1:0]  req_ready, mem_wr, mdr_load, done, err_align;
  logic [2:0]  size_sel [2];
  logic [31:0] mem_addr [2];

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_op    = req_op[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus1.req_valid = req_valid[1];
  assign bus1.req_op    = req_op[1];
  assign bus1.req_addr  = req_addr[1];

  assign req_ready = {bus1.req_ready, bus0.req_ready};
  assign mem_wr    = {bus1.mem_wr,    bus0.mem_wr};
  assign mdr_load  = {bus1.mdr_load,  bus0.mdr_load};
  assign done      = {bus1.done,      bus0.done};
  assign err_align = {bus1.err_align, bus0.err_align};
  assign size_sel[0] = bus0.size_sel;
  assign size_sel[1] = bus1.size_sel;
  assign mem_addr[0] = bus0.mem_addr;
  assign mem_addr[1] = bus1.mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check_eq($sformatf("%s.ready%0d", tag, d), 32'(req_ready[d]), 32'd1);
    check_eq($sformatf("%s.size%0d", tag, d), 32'(size_sel[d]), 32'd7);
    check_eq($sformatf("%s.addr%0d", tag, d), mem_addr[d], 32'd0);
    check_eq($sformatf("%s.strobes%0d", tag, d),
             {28'd0, mem_wr[d], mdr_load[d], done[d], err_align[d]}, 32'd0);
  endtask

  // Model: accept edge is cycle 0. Loads/rmw read for MEM_LAT cycles, then capture or
  // write, then done. sw writes at once. Illegal and (when checked) misaligned finish
  // immediately with no memory effect.
  task automatic run_txn(input int d, input logic [2:0] op, input logic [31:0] addr,
                         input bit noise);
    int lat, exp_done, exp_wr, exp_ld, exp_err;
    int done_at, wr_n, wr_at, ld_n, ld_at, err_seen, stray_err;
    int sz_bad, ad_bad, both, rdy_bad, waited;
    bit is_ld, is_st, is_rmw, bad, mis;
    string t;
    lat    = (d == 1) ? int'(LAT1) : int'(LAT0);
    is_ld  = (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    is_st  = (op == 3'b001);
    is_rmw = (op == 3'b000) || (op == 3'b010);
    bad    = (op >= 3'b110);
    mis    = 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    mis = (((op == 3'b010) || (op == 3'b101)) && addr[0]) ||
          (((op == 3'b100) || (op == 3'b001)) && (addr[1:0] != 2'b00));
`endif
    if (bad || mis) begin
      exp_done = 1; exp_wr = 0; exp_ld = 0;
    end else if (is_st) begin
      exp_done = 2; exp_wr = 1; exp_ld = 0;
    end else begin
      exp_done = lat + 2;
      exp_wr   = is_rmw ? lat + 1 : 0;
      exp_ld   = is_ld  ? lat + 1 : 0;
    end
    exp_err = mis ? 1 : 0;
    t = $sformatf("d%0d.op%0d.a%0h", d, op, addr);

    waited = 0;
    while (!req_ready[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({t, ".ready_in"}, 32'(req_ready[d]), 32'd1);

    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_addr[d]  = addr;
    @(posedge clk);

    done_at = 0; wr_n = 0; wr_at = 0; ld_n = 0; ld_at = 0; err_seen = 0; stray_err = 0;
    sz_bad = 0; ad_bad = 0; both = 0; rdy_bad = 0;
    for (int k = 1; k <= 12 && done_at == 0; k++) begin
      @(negedge clk);
      if (mem_wr[d])   begin wr_n++; wr_at = k; end
      if (mdr_load[d]) begin ld_n++; ld_at = k; end
      if (mem_wr[d] && mdr_load[d]) both++;
      if (size_sel[d] !== op)  sz_bad++;
      if (mem_addr[d] !== addr) ad_bad++;
      if (req_ready[d]) rdy_bad++;
      if (err_align[d] && !done[d]) stray_err++;
      if (done[d]) begin
        done_at  = k;
        err_seen = int'(err_align[d]);
      end
      if (noise && done_at == 0) begin
        req_valid[d] = 1'($urandom_range(0, 1));
        req_op[d]    = 3'($urandom);
        req_addr[d]  = $urandom;
      end else begin
        req_valid[d] = 1'b0;
      end
    end

    check_eq({t, ".done_cyc"}, done_at, exp_done);
    check_eq({t, ".wr_cnt"}, wr_n, (exp_wr != 0) ? 1 : 0);
    check_eq({t, ".wr_cyc"}, wr_at, exp_wr);
    check_eq({t, ".ld_cnt"}, ld_n, (exp_ld != 0) ? 1 : 0);
    check_eq({t, ".ld_cyc"}, ld_at, exp_ld);
    check_eq({t, ".err"}, err_seen, exp_err);
    check_eq({t, ".err_stray"}, stray_err, 0);
    check_eq({t, ".size_stable"}, sz_bad, 0);
    check_eq({t, ".addr_stable"}, ad_bad, 0);
    check_eq({t, ".wr_and_ld"}, both, 0);
    check_eq({t, ".busy_ready"}, rdy_bad, 0);

    @(negedge clk);
    check_eq({t, ".post_ready"}, 32'(req_ready[d]), 32'd1);
    check_eq({t, ".post_size"}, 32'(size_sel[d]), 32'(op));
    check_eq({t, ".post_addr"}, mem_addr[d], addr);
    check_eq({t, ".post_done"}, 32'(done[d]), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_wr, gap_done, d;
    logic [2:0]  op;
    logic [31:0] addr;

    reset     = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_op[i]   = 3'b000;
      req_addr[i] = 32'd0;
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_vals(0, "por");
    check_reset_vals(1, "por");
    reset = 1'b0;
    @(negedge clk);

    run_txn(0, 3'b001, 32'h0000_0010, 1'b0);
    run_txn(0, 3'b100, 32'h0000_0020, 1'b0);
    run_txn(0, 3'b000, 32'h0000_0013, 1'b0);
    run_txn(1, 3'b101, 32'h0000_0004, 1'b0);
    run_txn(0, 3'b100, 32'h0000_0002, 1'b0);
    run_txn(1, 3'b110, 32'h0000_0008, 1'b0);
    run_txn(0, 3'b111, 32'h0000_0009, 1'b1);

    // Reset in the middle of an sh read phase.
    req_valid[1] = 1'b1;
    req_op[1]    = 3'b010;
    req_addr[1]  = 32'h0000_0006;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals(1, "midrst");
    check_reset_vals(0, "midrst");
    @(negedge clk);
    reset = 1'b0;
    gap_wr = 0;
    gap_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_wr[1]) gap_wr++;
      if (done[1])   gap_done++;
    end
    check_eq("midrst.no_wr", gap_wr, 0);
    check_eq("midrst.no_done", gap_done, 0);
    run_txn(1, 3'b010, 32'h0000_0006, 1'b0);

    for (int i = 0; i < 160; i++) begin
      d    = int'($urandom_range(0, 1));
      op   = 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_txn(d, op, addr, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
